bit_counter_n: RTL

//  Parametrised successor to the 4-bit lab counter: WIDTH-bit up/down counter with

---
 rtl/bitcounter_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 43 ++++
 rtl/bit_counter_n.sv | 107 ++++++++++
 3 files changed

// File: rtl/bitcounter_pkg.sv
// Shared constants and helpers for the bit_counter_n counting primitive.
package bitcounter_pkg;

  // Encodings of the 'up' and 'sat' control inputs.
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Ceiling log2; used at elaboration time to size the prescaler.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: asserts step_en on every PRESCALE-th enabled cycle.
module tick_prescaler
  import bitcounter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step_en
);

  // A single-phase prescaler still keeps a 1-bit register; it never leaves 0.
  localparam int PW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LastPhase = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          last_phase;

  assign last_phase = (presc_q == LastPhase);
  assign step_en    = en & last_phase;

  // Next phase: clear wins, otherwise advance on enabled cycles and wrap at the last phase.
  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = last_phase ? '0 : presc_q + PW'(1);
    end
  end

  // Phase register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/bit_counter_n.sv
// WIDTH-bit up/down counter with programmable modulus, wrap/saturate mode,
// parallel load, clock-enable prescaler, terminal-count pulse and sticky overflow.
module bit_counter_n
  import bitcounter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             tick,
  output logic             tc,
  output logic             ovf
);

  localparam longint MaxLegal = (longint'(1) << WIDTH) - 1;

  // Refuse to elaborate with a modulus or prescale the counter cannot honour.
  if (WIDTH < 1 || PRESCALE < 1 || MAX_VAL < 1 || longint'(MAX_VAL) > MaxLegal) begin : g_bad_params
    $error("bit_counter_n: illegal WIDTH/MAX_VAL/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step_en;
  logic             step;
  logic             at_top;
  logic             at_bot;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .clr     (load),
    .step_en (step_en)
  );

  // Load and reset both pre-empt a step that would otherwise fall on this cycle.
  assign step   = step_en & ~load & ~reset;
  assign at_top = (counter_q == MaxV);
  assign at_bot = (counter_q == '0);

  // Next-value mux: load > step > hold; bound hits raise tc and ovf.
  always_comb begin
    counter_d = counter_q;
    tick_d    = 1'b0;
    tc_d      = 1'b0;
    ovf_d     = ovf_q;
    if (load) begin
      counter_d = (load_val > MaxV) ? MaxV : load_val;
      ovf_d     = 1'b0;
    end else if (step) begin
      tick_d = 1'b1;
      if (up == DIR_UP) begin
        if (at_top) begin
          tc_d      = 1'b1;
          ovf_d     = 1'b1;
          counter_d = (sat == MODE_SAT) ? MaxV : '0;
        end else begin
          counter_d = counter_q + WIDTH'(1);
        end
      end else begin
        if (at_bot) begin
          tc_d      = 1'b1;
          ovf_d     = 1'b1;
          counter_d = (sat == MODE_SAT) ? '0 : MaxV;
        end else begin
          counter_d = counter_q - WIDTH'(1);
        end
      end
    end
  end

  // Count and flag registers; reset zeroes everything with no tick or tc.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= '0;
      tick_q    <= 1'b0;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      tick_q    <= tick_d;
      tc_q      <= tc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign counter = counter_q;
  assign tick    = tick_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;

endmodule
